writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Drives the register-file write port (write_reg, write_data, RegWrite) from two producer channels: the ALU result channel and the load-return channel. One write is committed per cycle. Loads have priority. ALU results that lose arbitration wait in a small in-order FIFO. The block also keeps a per-register busy scoreboard, which decode queries to stall on pending writes.

Parameters:
XLEN, 32, data width of results and write_data
NREG, 32, number of architectural registers (address width 5)
FIFO_DEPTH, 2, ALU result FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted at 0)
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load result present (always accepted)
ld_rd  in  5  load destination register
ld_data  in  XLEN  load result
issue_valid  in  1  decode issued an instruction that writes issue_rd
issue_rd  in  5  destination of the issued instruction
rs1  in  5  scoreboard query address 1
rs2  in  5  scoreboard query address 2
rs1_busy  out  1  rs1 has a pending write (combinational)
rs2_busy  out  1  rs2 has a pending write (combinational)
write_reg  out  5  register-file write address (registered)
write_data  out  XLEN  register-file write data (registered)
RegWrite  out  1  register-file write enable (registered)
fifo_count  out  $clog2(FIFO_DEPTH)+1  ALU FIFO occupancy

Behaviour:
- Reset (reset=0, async): RegWrite=0, write_reg=0, write_data=0, FIFO emptied (fifo_count=0), all busy bits cleared. A reset mid-operation discards queued results with no write.
- alu_ready = (fifo_count < FIFO_DEPTH). It is combinational on state only and never depends on alu_valid or ld_valid.
- Source selection each cycle, in priority order:
  - (1) ld_valid.
  - (2) FIFO head, if fifo_count>0.
  - (3) Direct ALU input (alu_valid && alu_ready), only when the FIFO is empty.
- An accepted ALU result that is not selected in the same cycle is enqueued at the FIFO tail. ALU results commit strictly in acceptance order.
- The selected result is registered. Next cycle: RegWrite=1, write_reg=rd, write_data=data. Latency from acceptance to RegWrite is 1 cycle when selected immediately.
- No source selected: RegWrite=0 next cycle. write_reg and write_data hold their previous values.
- rd=0 results:
  - Accepted but never enqueued and never written.
  - RegWrite=0 for that slot.
  - A selected rd=0 result still consumes the slot, so lower-priority sources wait one cycle.
- Simultaneous enqueue and dequeue: permitted when the FIFO is non-full. Count is unchanged and ordering is preserved.
- FIFO full, with load and ALU both valid: load is written, alu_ready=0, ALU result held by the producer.
- Scoreboard: busy[NREG] flops, with busy[0] tied 0.
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - Selecting a result with rd!=0 clears busy[rd] at the same edge at which RegWrite is registered.
  - Set and clear of the same register in one cycle: set wins, because a newer producer exists.
- rs1_busy=busy[rs1] and rs2_busy=busy[rs2], read from flop state with no bypass. A register whose write appears on RegWrite this cycle already reads not-busy. The register file absorbs the write at the same edge.
- Widths: rd fields are 5 bits. Data is passed unmodified, with no sign or extension handling.

Decomposition:
- Package wb_pkg holds:
  - XLEN and REG_AW=5.
  - wb_req_t, a packed struct {rd[REG_AW], data[XLEN]}.
  - Source enum src_e {SRC_NONE, SRC_LD, SRC_FIFO, SRC_ALU}.
- Sub-module wb_fifo:
  - Parameterised synchronous FIFO of wb_req_t with DEPTH.
  - Interface: push, pop, head, count, full, empty.
  - Uses the same clk/reset.
- Arbitration and the scoreboard stay in writeback_unit.

Test Plan:
- Reset low for 3 cycles, then release: RegWrite=0, write_reg=0, write_data=0, fifo_count=0, rs1_busy=rs2_busy=0 for all rs.
- Single ALU result (alu_rd=5, alu_data=0xDEADBEEF) on an idle unit: alu_ready=1; next cycle RegWrite=1, write_reg=5, write_data=0xDEADBEEF; the following cycle RegWrite=0.
- Load and ALU in the same cycle (ld_rd=3/0x11, alu_rd=4/0x22):
  - Cycle+1 writes reg 3 = 0x11, with fifo_count=1.
  - Cycle+2 writes reg 4 = 0x22, with fifo_count=0.
- Back-pressure with loads on 4 consecutive cycles and ALU valid throughout (rd 6,7,8):
  - ALU rd 6 and 7 are enqueued, then alu_ready=0 at fifo_count=2.
  - After the loads stop, writes appear in order 6, 7, 8.
- Scoreboard:
  - issue rd=9 gives rs1=9 busy=1.
  - ALU rd=9 committed gives busy=0 on the cycle RegWrite shows reg 9.
  - issue_rd=9 in the same cycle as the commit keeps busy=1.
  - issue rd=0 never sets busy.
- rd=0 result with alu_data=0xFFFF_FFFF: RegWrite stays 0 and no busy change. Reset asserted with fifo_count=2 empties the FIFO, and no write appears after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback path: result payload and arbitration source tags.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_FIFO,
        SRC_ALU
    } src_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order holding queue for ALU results that lost arbitration; head is visible same cycle.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps the count.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter (load > queued ALU > direct ALU) plus busy scoreboard.
// One registered write per cycle, 1-cycle latency; alu_ready drops only when the ALU queue is full.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 2,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [REG_AW-1:0] write_reg,
    output logic [XLEN-1:0]   write_data,
    output logic              RegWrite,
    output logic [CW-1:0]     fifo_count
);

    src_e            sel;
    wb_req_t         sel_req;
    wb_req_t         alu_req;
    wb_req_t         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            alu_acc;
    logic            push;
    logic            pop;
    logic            commit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    assign alu_ready = !fifo_full;
    assign alu_acc   = alu_valid && alu_ready;
    assign alu_req   = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (alu_req),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Direct ALU bypass only when the queue is empty, which preserves acceptance order.
    always_comb begin
        sel     = SRC_NONE;
        sel_req = '0;
        if (ld_valid) begin
            sel     = SRC_LD;
            sel_req = '{rd: ld_rd, data: ld_data};
        end else if (!fifo_empty) begin
            sel     = SRC_FIFO;
            sel_req = fifo_head;
        end else if (alu_acc) begin
            sel     = SRC_ALU;
            sel_req = alu_req;
        end
        push   = alu_acc && (sel != SRC_ALU) && (alu_rd != '0);
        pop    = (sel == SRC_FIFO);
        commit = (sel != SRC_NONE) && (sel_req.rd != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            RegWrite <= commit;
            if (commit) begin
                write_reg  <= sel_req.rd;
                write_data <= sel_req.data;
            end
        end
    end

    // A same-cycle issue means a newer producer exists, so the set overrides the clear.
    always_comb begin
        busy_next = busy;
        if (commit) begin
            busy_next[sel_req.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign rs1_busy = busy[rs1];
    assign rs2_busy = busy[rs2];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model of the writeback rules.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        RegWrite;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [36:0] mq[$];
    bit        mbusy[32];
    bit        m_we;
    bit [4:0]  m_reg;
    bit [31:0] m_data;
    bit        m_acc;

    always #5 clk = ~clk;

    writeback_unit #(.NREG(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
        .fifo_count(fifo_count)
    );

    function automatic void model_reset();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        m_we = 1'b0; m_reg = '0; m_data = '0; m_acc = 1'b0;
    endfunction

    // One clock edge of the writeback rules, evaluated on the current inputs.
    function automatic void model_edge();
        bit        have = 1'b0;
        bit        took_alu = 1'b0;
        bit [4:0]  srd = '0;
        bit [31:0] sdat = '0;
        bit [36:0] e;
        m_acc = alu_valid && (mq.size() < DEPTH);
        if (ld_valid) begin
            have = 1'b1; srd = ld_rd; sdat = ld_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            have = 1'b1; srd = e[36:32]; sdat = e[31:0];
        end else if (m_acc) begin
            have = 1'b1; srd = alu_rd; sdat = alu_data; took_alu = 1'b1;
        end
        if (m_acc && !took_alu && alu_rd != 0) mq.push_back({alu_rd, alu_data});
        m_we = have && (srd != 0);
        if (m_we) begin
            m_reg = srd; m_data = sdat; mbusy[srd] = 1'b0;
        end
        if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we_low got %0b exp 0", RegWrite); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", RegWrite); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_reg got %0d exp 0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_data got %0h exp 0", write_data); end
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", alu_ready); end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r);
            #1;
            checks++;
            if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy rs %0d got %0b/%0b exp 0/0", r, rs1_busy, rs2_busy);
            end
        end
        tick();
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", alu_ready); end
        tick();
        idle();
        checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL single_we got %0b exp 1", RegWrite); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_reg got %0d exp 5", write_reg); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %0h exp deadbeef", write_data); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_we_after got %0b exp 0", RegWrite); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL single_reg_hold got %0d exp 5", write_reg); end
    endtask

    task automatic test_ld_alu_same_cycle();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL ldalu_ready got %0b exp 1", alu_ready); end
        tick();
        idle();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h11) begin
            errors++; $display("FAIL ldalu_first got we=%0b r%0d=%0h exp we=1 r3=11", RegWrite, write_reg, write_data); end
        checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL ldalu_count1 got %0d exp 1", fifo_count); end
        tick();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h22) begin
            errors++; $display("FAIL ldalu_second got we=%0b r%0d=%0h exp we=1 r4=22", RegWrite, write_reg, write_data); end
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL ldalu_count0 got %0d exp 0", fifo_count); end
        tick();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL ldalu_idle got %0b exp 0", RegWrite); end
    endtask

    task automatic test_backpressure();
        bit [4:0] alu_seq[3];
        int       exp_order[7];
        int       got[$];
        int       n_alu = 0;
        alu_seq   = '{5'd6, 5'd7, 5'd8};
        exp_order = '{20, 21, 22, 23, 6, 7, 8};
        for (int cyc = 0; cyc < 10; cyc++) begin
            ld_valid  = (cyc < 4);
            ld_rd     = 5'(20 + cyc);
            ld_data   = $urandom;
            alu_valid = (n_alu < 3);
            alu_rd    = (n_alu < 3) ? alu_seq[n_alu] : 5'd0;
            alu_data  = 32'hA000_0000 | 32'(alu_rd);
            #1;
            if (cyc == 2 || cyc == 3) begin
                checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL bp_full_count c%0d got %0d exp 2", cyc, fifo_count); end
                checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low c%0d got %0b exp 0", cyc, alu_ready); end
            end
            tick();
            if (m_acc) n_alu++;
            checks++; if (RegWrite !== m_we) begin errors++; $display("FAIL bp_we c%0d got %0b exp %0b", cyc, RegWrite, m_we); end
            if (RegWrite === 1'b1) got.push_back(int'(write_reg));
        end
        idle();
        checks++; if (got.size() != 7) begin errors++; $display("FAIL bp_nwrites got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_order[i]) begin errors++; $display("FAIL bp_order idx %0d got %0d exp %0d", i, got[i], exp_order[i]); end
        end
    endtask

    task automatic test_scoreboard();
        rs1 = 5'd9; rs2 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_set got %0b exp 1", rs1_busy); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        idle();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd9) begin errors++; $display("FAIL sb_commit got we=%0b r%0d exp we=1 r9", RegWrite, write_reg); end
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear got %0b exp 0", rs1_busy); end
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h98;
        tick();
        idle();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd9) begin errors++; $display("FAIL sb_commit2 got we=%0b r%0d exp we=1 r9", RegWrite, write_reg); end
        checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %0b exp 1", rs2_busy); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h97;
        tick();
        idle();
        checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_clear2 got %0b exp 0", rs1_busy); end
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        rs1 = 5'd0; rs2 = 5'd0;
        #1;
        checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL sb_r0 got %0b/%0b exp 0/0", rs1_busy, rs2_busy); end
    endtask

    task automatic test_rd0();
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        tick();
        idle();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rd0_we got %0b exp 0", RegWrite); end
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rd0_count got %0d exp 0", fifo_count); end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            #1;
            checks++; if (rs1_busy !== mbusy[r]) begin errors++; $display("FAIL rd0_busy r%0d got %0b exp %0b", r, rs1_busy, mbusy[r]); end
        end
        // A rd=0 load still takes the slot, so the ALU result goes out one cycle later.
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h1313;
        tick();
        idle();
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rd0_ld_slot got %0b exp 0", RegWrite); end
        tick();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd13 || write_data !== 32'h1313) begin
            errors++; $display("FAIL rd0_after got we=%0b r%0d=%0h exp we=1 r13=1313", RegWrite, write_reg, write_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            ld_valid = 1'b1; ld_rd = 5'(16 + c); ld_data = 32'(c);
            alu_valid = 1'b1; alu_rd = 5'(14 + c); alu_data = 32'hC0DE_0000 + 32'(c);
            tick();
        end
        idle();
        #1;
        checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL rstmid_full got %0d exp 2", fifo_count); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", fifo_count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rstmid_we got %0b exp 0", RegWrite); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rstmid_nowrite c%0d got %0b exp 0", c, RegWrite); end
            checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rstmid_empty c%0d got %0d exp 0", c, fifo_count); end
        end
    endtask

    task automatic test_random();
        idle();
        m_acc = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_rd    = 5'($urandom);
            ld_data  = $urandom;
            if (!alu_valid || m_acc) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom);
            rs1         = 5'($urandom);
            rs2         = 5'($urandom);
            #1;
            checks++; if (alu_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %0b exp %0b", cyc, alu_ready, mq.size() < DEPTH); end
            checks++; if (fifo_count !== 2'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", cyc, fifo_count, mq.size()); end
            checks++; if (rs1_busy !== mbusy[rs1]) begin errors++; $display("FAIL rnd_rs1 c%0d r%0d got %0b exp %0b", cyc, rs1, rs1_busy, mbusy[rs1]); end
            checks++; if (rs2_busy !== mbusy[rs2]) begin errors++; $display("FAIL rnd_rs2 c%0d r%0d got %0b exp %0b", cyc, rs2, rs2_busy, mbusy[rs2]); end
            tick();
            checks++; if (RegWrite !== m_we) begin errors++; $display("FAIL rnd_we c%0d got %0b exp %0b", cyc, RegWrite, m_we); end
            if (m_we) begin
                checks++; if (write_reg !== m_reg || write_data !== m_data) begin
                    errors++; $display("FAIL rnd_write c%0d got r%0d=%0h exp r%0d=%0h", cyc, write_reg, write_data, m_reg, m_data); end
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_alu();
        test_ld_alu_same_cycle();
        test_backpressure();
        test_scoreboard();
        test_rd0();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
